muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle sequencer for the RV32M multiply/divide operations in the execute stage. It replaces the single-cycle `*`, `/` and `%` paths with a handshaked unit: multiplies complete in one cycle, and divides/remainders run a 32-step radix-2 restoring iteration. The front end stalls issue while `req_ready` is low. Results return over a valid/ready response channel into the execute-stage result mux.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  abandon any in-flight operation (branch mispredict or trap).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_op`  in  3  `muldiv_op_t`: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7 (funct3 encoding).
- `rs1`  in  32  dividend / multiplicand.
- `rs2`  in  32  divisor / multiplier.
- `resp_valid`  out  1  `rd` holds a result.
- `resp_ready`  in  1  consumer accepts the result.
- `rd`  out  32  result, registered.
- `busy`  out  1  high in CALC or DONE.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - CALC: iterating.
  - DONE: `resp_valid`=1.
- IDLE transitions (on `req_valid`):
  - Multiply op: compute the 64-bit product in the same cycle, go to DONE. Operand extension per op:
    - MUL, MULH: signed×signed.
    - MULHSU: signed×unsigned.
    - MULHU: unsigned×unsigned.
    - MUL returns bits [31:0]; the others return [63:32].
  - Divide op with a special case (see below): write the result directly, go to DONE.
  - Otherwise: latch |rs1| into the quotient register and |rs2| into the divisor register. For unsigned ops the absolute value is the raw value. Clear the remainder, load the iteration counter with 31, record `neg_q` = sign(rs1)^sign(rs2) and `neg_r` = sign(rs1) (both forced to 0 for unsigned ops), go to CALC.
- CALC, each cycle:
  - Form {rem,quo} shifted left by 1, then trial = rem_shifted − divisor (33-bit).
  - If trial is non-negative: rem ← trial[31:0], quo[0] ← 1. Otherwise: rem ← rem_shifted, quo[0] ← 0.
  - Counter decrements. When the counter is 0, after that update, apply the sign fix-ups (negate q if `neg_q`, negate r if `neg_r`), write `rd` (quotient for DIV/DIVU, remainder for REM/REMU), go to DONE.
- DONE: hold `rd` stable. On `resp_ready`, go to IDLE.
- Special cases (always one-cycle):
  - rs2==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- `flush` is asserted in any state → IDLE next edge. Any pending result is discarded, `resp_valid` drops, and `rd` is unchanged. `flush` and `req_valid` together in IDLE: the request is not accepted.
- Reset values: state=IDLE, `rd`=0, `resp_valid`=0, `busy`=0, `req_ready`=1 (combinational from state). All internal registers are 0.

## Timing
- Request accepted at edge T.
- Multiply or special case: `resp_valid` high from T+1.
- General divide: CALC occupies T+1..T+32, and `resp_valid` is high from T+33.
- Back-to-back: after a response is accepted at edge R, `req_ready` is high from R+1. There is no same-cycle turnaround.
- Response: `rd`/`resp_valid` stay stable until the cycle in which `resp_ready`=1; the response is consumed at that edge.
- Reset asserted mid-CALC: everything clears asynchronously, and no response is produced.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: in IDLE, a non-special divide with |rs1| < |rs2| (unsigned compare of the magnitudes) completes in one cycle with q=0 and r=rs1 (original signed value). This gives latency 1.
- Not defined: such operands take the full 33-cycle path. The results are bit-identical either way.

## Structure
- The shared package `def.sv` holds the `muldiv_op_t` enum and the constants `MULDIV_ITER=32` and `DIV_ZERO_Q=32'hFFFFFFFF`.
- One sub-module, `div_step`: combinational single restoring step. Inputs are rem, quo and divisor; outputs are the next rem and quo. `muldiv_ctrl` owns the FSM, counter, sign fix-up and handshake.
- The multiplier stays inline, since it is a single registered 64-bit product.

## Test plan
- MULH with rs1=0xFFFFFFFF (−1), rs2=0x00000002: `resp_valid` at T+1, `rd`=0xFFFFFFFF. MULHU with the same operands: `rd`=0x00000001.
- DIVU 100/7: `req_ready` low T+1..T+33, `resp_valid` at T+33, `rd`=14. REMU with the same operands: `rd`=2.
- REM with rs1=0xFFFFFFF9 (−7), rs2=2: `rd`=0xFFFFFFFF (−1). DIV with the same operands: `rd`=0xFFFFFFFD (−3).
- Special cases:
  - DIV x/0 with rs1=5: `rd`=0xFFFFFFFF at T+1.
  - REM with rs1=0x80000000, rs2=0xFFFFFFFF: `rd`=0 at T+1.
- `resp_ready` held low for 5 cycles after DONE: `rd` is stable throughout and `req_ready` stays low. Then `flush` asserted at T+10 of a DIVU: IDLE at T+11, and no response is produced.
- DIVU 3/10: with `MULDIV_EARLY_OUT_EN`, `rd`=0 at T+1; without it, `rd`=0 at T+33.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int MULDIV_ITER = 32;
    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // Matches funct3 of the RV32M encodings.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response channel between the execute stage and muldiv_ctrl.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic             flush;
    logic             req_valid;
    logic             req_ready;
    muldiv_op_t       req_op;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  rd;
    logic             busy;

    modport master (
        output flush, req_valid, req_op, rs1, rs2, resp_ready,
        input  req_ready, resp_valid, rd, busy
    );

    modport slave (
        input  flush, req_valid, req_op, rs1, rs2, resp_ready,
        output req_ready, resp_valid, rd, busy
    );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One radix-2 restoring division step on magnitudes (purely combinational).
module div_step
    import muldiv_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_trial;

    // rem < divisor always holds, so the shifted remainder fits in 33 bits
    // and a non-negative trial always fits back into 32.
    assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
    assign w_trial  = w_rem_sh - {1'b0, i_dvs};
    assign o_rem    = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
    assign o_quo    = {i_quo[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: 1-cycle multiply, 32-step restoring divide.
// Optional MULDIV_EARLY_OUT_EN: finish divides with |rs1| < |rs2| in one cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    muldiv_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    muldiv_op_t      r_op;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [4:0]      r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_rd;

    logic            w_is_div;
    logic            w_is_rem;
    logic            w_sdiv;
    logic            w_sa;
    logic            w_sb;
    logic [63:0]     w_ma;
    logic [63:0]     w_mb;
    logic [63:0]     w_prod;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    assign w_is_div = bus.req_op[2];
    assign w_is_rem = bus.req_op[1];
    assign w_sdiv   = ~bus.req_op[0];

    // Sign-extending to 64 bits lets one unsigned multiply cover all four
    // multiply flavours; the low 64 bits are correct modulo 2^64.
    assign w_sa      = bus.rs1[XLEN-1] & (bus.req_op != MULHU);
    assign w_sb      = bus.rs2[XLEN-1] & ((bus.req_op == MUL) | (bus.req_op == MULH));
    assign w_ma      = {{32{w_sa}}, bus.rs1};
    assign w_mb      = {{32{w_sb}}, bus.rs2};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (bus.req_op == MUL) ? w_prod[31:0] : w_prod[63:32];

    assign w_abs1 = (w_sdiv & bus.rs1[XLEN-1]) ? (~bus.rs1 + 32'd1) : bus.rs1;
    assign w_abs2 = (w_sdiv & bus.rs2[XLEN-1]) ? (~bus.rs2 + 32'd1) : bus.rs2;
    assign w_div0 = (bus.rs2 == '0);
    assign w_ovf  = w_sdiv & (bus.rs1 == 32'h8000_0000) & (bus.rs2 == 32'hFFFF_FFFF);

    div_step u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nx),
        .o_quo (w_quo_nx)
    );

    assign w_q_fix = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
    assign w_r_fix = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_op    <= MUL;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_rd    <= '0;
        end else if (bus.flush) begin
            // Abandon whatever is in flight; rd keeps its last value.
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op <= bus.req_op;
                        if (!w_is_div) begin
                            r_rd    <= w_mul_res;
                            r_state <= S_DONE;
                        end else if (w_div0) begin
                            r_rd    <= w_is_rem ? bus.rs1 : DIV_ZERO_Q;
                            r_state <= S_DONE;
                        end else if (w_ovf) begin
                            r_rd    <= w_is_rem ? '0 : 32'h8000_0000;
                            r_state <= S_DONE;
`ifdef MULDIV_EARLY_OUT_EN
                        end else if (w_abs1 < w_abs2) begin
                            r_rd    <= w_is_rem ? bus.rs1 : '0;
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_quo   <= w_abs1;
                            r_dvs   <= w_abs2;
                            r_rem   <= '0;
                            r_cnt   <= 5'(MULDIV_ITER - 1);
                            r_neg_q <= w_sdiv & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
                            r_neg_r <= w_sdiv & bus.rs1[XLEN-1];
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == '0) begin
                        r_rd    <= r_op[1] ? w_r_fix : w_q_fix;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_DONE);
    assign bus.busy       = (r_state == S_CALC) | (r_state == S_DONE);
    assign bus.rd         = r_rd;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_rd;

    muldiv_ctrl_if bus();

    muldiv_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] p;
        longint sa;
        longint sb;
        logic [63:0] t;
        if (op < 3'd4) begin
            x = (op != 3'd3) ? 64'($signed(a)) : {32'd0, a};
            y = (op <= 3'd1) ? 64'($signed(b)) : {32'd0, b};
            p = x * y;
            return (op == 3'd0) ? p[31:0] : p[63:32];
        end
        sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        t = op[1] ? 64'(sa % sb) : 64'(sa / sb);
        return t[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        longint sa;
        longint sb;
        if (op < 3'd4 || b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
`ifdef MULDIV_EARLY_OUT_EN
        if (sa < sb) return 1;
`endif
        return 33;
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        int lat;
        int n;
        int exp_lat;
        logic [31:0] exp_rd;
        exp_rd  = ref_res(op, a, b);
        exp_lat = ref_lat(op, a, b);
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) chk("req_ready_timeout", 32'(n), 32'd0);
        bus.req_op    = muldiv_op_t'(op);
        bus.rs1       = a;
        bus.rs2       = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        if (exp_lat > 1) begin
            chk("calc_req_ready", 32'(bus.req_ready), 32'd0);
            chk("calc_busy", 32'(bus.busy), 32'd1);
        end
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (!bus.resp_valid && bus.req_ready) begin
                chk("early_ready", 32'(bus.req_ready), 32'd0);
                lat = 100;
            end
        end
        chk($sformatf("lat op%0d %h/%h", op, a, b), 32'(lat), 32'(exp_lat));
        chk($sformatf("rd op%0d %h/%h", op, a, b), bus.rd, exp_rd);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_rd", bus.rd, exp_rd);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("after_resp_ready", 32'(bus.req_ready), 32'd1);
        chk("after_resp_valid", 32'(bus.resp_valid), 32'd0);
        last_rd = exp_rd;
    endtask

    task automatic no_resp(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        last_rd        = 32'd0;
        rstn           = 1'b0;
        bus.flush      = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = MUL;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", bus.rd, 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        rstn = 1'b1;
        @(posedge clk); #1;

        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'd2, 0);
        do_op(3'd5, 32'd100, 32'd7, 0);
        do_op(3'd7, 32'd100, 32'd7, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd4, 32'd5, 32'd0, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'd3, 32'd10, 0);
        do_op(3'd5, 32'd1000, 32'd9, 5);

        // Flush during CALC: asserted in cycle T+10, unit idle from T+11.
        bus.req_op    = DIVU;
        bus.rs1       = 32'd12345;
        bus.rs2       = 32'd7;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_rd_kept", bus.rd, last_rd);
        no_resp("flush_no_resp", 40);

        // Flush together with a request in IDLE: nothing accepted.
        bus.req_op    = MUL;
        bus.rs1       = 32'd3;
        bus.rs2       = 32'd4;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        chk("flush_req_busy", 32'(bus.busy), 32'd0);
        chk("flush_req_ready2", 32'(bus.req_ready), 32'd1);
        chk("flush_req_rd", bus.rd, last_rd);

        // Asynchronous reset in the middle of a divide.
        bus.req_op    = DIV;
        bus.rs1       = 32'hFFFF_0000;
        bus.rs2       = 32'd13;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_rd", bus.rd, 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        last_rd = 32'd0;
        no_resp("arst_no_resp", 40);

        for (int i = 0; i < 200; i++)
            do_op(3'($urandom_range(0, 7)), pick_val(), pick_val(), $urandom_range(0, 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
